// File: rtl/multi_cycle_seq.sv
// Multi-cycle instruction sequencer: owns PC, IR and the FETCH/DECODE/EXEC/MEM/WB control FSM.
// Optional memory-wait watchdog enabled by defining MC_SEQ_TIMEOUT_EN.
module multi_cycle_seq #(
    parameter int          PC_W        = 32,
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    input  logic            i_dmem_ack,
    input  logic            i_is_load,
    input  logic            i_is_store,
    input  logic            i_rd_wren,
    input  logic            i_pc_sel,
    input  logic            i_illegal,
    input  logic [31:0]     i_alu_result,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_plus4,
    output logic [31:0]     o_inst,
    output logic            o_rd_wren,
    output logic            o_ld_capture,
    output logic            o_retire,
    output logic [2:0]      o_state,
    output logic            o_trap,
    output logic [1:0]      o_trap_cause
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b10;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b11;

    logic [2:0]      state_reg;
    logic [2:0]      state_next;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] pc_target;
    logic [31:0]     ir_reg;
    logic            trap_reg;
    logic [1:0]      cause_reg;
    logic [1:0]      cause_next;
    logic            wb_misaligned;
    logic            timed_out;

    assign pc_plus4      = pc_reg + PC_W'(4);
    assign pc_target     = i_pc_sel ? (i_alu_result[PC_W-1:0] & {{(PC_W-1){1'b1}}, 1'b0})
                                    : pc_plus4;
    assign wb_misaligned = |pc_target[1:0];

`ifdef MC_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             mem_wait;
    logic             mem_ack;

    assign mem_wait  = (state_reg == S_FETCH) || (state_reg == S_MEM);
    assign mem_ack   = ((state_reg == S_FETCH) && i_imem_ack) ||
                       ((state_reg == S_MEM)   && i_dmem_ack);
    // An ack arriving on the limit cycle still wins over the timeout.
    assign timed_out = mem_wait && !mem_ack && (wait_cnt_reg == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wait_cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            wait_cnt_reg <= '0;
        end else if (mem_wait && !mem_ack) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end
    end
`else
    assign timed_out = (MEM_TIMEOUT < 0);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            S_FETCH: begin
                if (timed_out) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end else if (i_imem_ack) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (i_illegal) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else if (i_is_load || i_is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (timed_out) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end else if (i_dmem_ack) begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                if (wb_misaligned) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_MISALIGNED;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    // Requests and pulses are held low while reset is asserted.
    always_comb begin
        o_imem_req   = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_ld_capture = 1'b0;
        o_retire     = 1'b0;
        o_rd_wren    = 1'b0;
        if (i_rst) begin
            case (state_reg)
                S_FETCH: o_imem_req = 1'b1;
                S_MEM: begin
                    o_dmem_req   = 1'b1;
                    o_dmem_we    = i_is_store;
                    o_ld_capture = i_dmem_ack && !i_is_store;
                end
                S_WB: begin
                    o_retire  = !wb_misaligned;
                    o_rd_wren = !wb_misaligned && i_rd_wren && !i_is_store;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pc_reg    <= RESET_VEC[PC_W-1:0];
            ir_reg    <= 32'h0000_0013;
            trap_reg  <= 1'b0;
            cause_reg <= 2'b00;
        end else begin
            if ((state_reg == S_FETCH) && i_imem_ack) begin
                ir_reg <= i_imem_rdata;
            end
            if ((state_reg == S_WB) && !wb_misaligned) begin
                pc_reg <= pc_target;
            end
            if (state_next == S_TRAP) begin
                trap_reg <= 1'b1;
            end
            cause_reg <= cause_next;
        end
    end

    assign o_imem_addr  = pc_reg;
    assign o_pc         = pc_reg;
    assign o_pc_plus4   = pc_plus4;
    assign o_inst       = ir_reg;
    assign o_state      = state_reg;
    assign o_trap       = trap_reg;
    assign o_trap_cause = cause_reg;

endmodule

// File: tb/tb_multi_cycle_seq.sv
// Directed bench for multi_cycle_seq: runs hand-written instruction transactions through the FSM.
// Timeout cases run only when MC_SEQ_TIMEOUT_EN is defined.
module tb_multi_cycle_seq;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;
    logic            is_load;
    logic            is_store;
    logic            rd_wren_in;
    logic            pc_sel;
    logic            illegal;
    logic [31:0]     alu_result;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;
    logic [31:0]     inst;
    logic            rd_wren;
    logic            ld_capture;
    logic            retire;
    logic [2:0]      state;
    logic            trap;
    logic [1:0]      trap_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_cycle_seq #(
        .PC_W       (PC_W),
        .RESET_VEC  (32'h0000_0100),
        .MEM_TIMEOUT(4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .i_dmem_ack   (dmem_ack),
        .i_is_load    (is_load),
        .i_is_store   (is_store),
        .i_rd_wren    (rd_wren_in),
        .i_pc_sel     (pc_sel),
        .i_illegal    (illegal),
        .i_alu_result (alu_result),
        .o_pc         (pc),
        .o_pc_plus4   (pc_plus4),
        .o_inst       (inst),
        .o_rd_wren    (rd_wren),
        .o_ld_capture (ld_capture),
        .o_retire     (retire),
        .o_state      (state),
        .o_trap       (trap),
        .o_trap_cause (trap_cause)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        dmem_ack   = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        rd_wren_in = 1'b0;
        pc_sel     = 1'b0;
        illegal    = 1'b0;
        alu_result = 32'h0;
    endtask

    // One reset cycle with a stray ack that must be ignored; leaves the DUT in its first FETCH cycle.
    task automatic do_reset();
        idle_inputs();
        rst      = 1'b0;
        imem_ack = 1'b1;
        step();
        #1;
        check_eq("rst_imem_req", imem_req, 0);
        check_eq("rst_state", state, 0);
        check_eq("rst_pc", pc, 32'h100);
        check_eq("rst_inst", inst, 32'h13);
        check_eq("rst_trap", trap, 0);
        check_eq("rst_cause", trap_cause, 0);
        check_eq("rst_retire", retire, 0);
        idle_inputs();
        rst = 1'b1;
        $display("TXN reset pc=%h state=%0d", pc, state);
    endtask

    task automatic run_inst(input string name, input logic [31:0] iw_data, input int iw, input int dw,
                            input logic ld, input logic st, input logic rdw, input logic psel,
                            input logic ill, input logic [31:0] alu,
                            input logic [31:0] exp_pc, input logic [31:0] exp_next,
                            input logic exp_rdw, input logic exp_trap, input int exp_cycles);
        int cyc = 0;
        for (int w = 0; w <= iw; w++) begin
            imem_ack   = (w == iw);
            imem_rdata = (w == iw) ? iw_data : 32'hffff_ffff;
            dmem_ack   = 1'b1;
            #1;
            check_eq({name, "_f_state"}, state, 0);
            check_eq({name, "_f_req"}, imem_req, 1);
            check_eq({name, "_f_addr"}, imem_addr, exp_pc);
            check_eq({name, "_f_dreq"}, dmem_req, 0);
            step();
            cyc++;
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hdead_beef;
        dmem_ack   = 1'b1;
        is_load    = ld;
        is_store   = st;
        rd_wren_in = rdw;
        pc_sel     = psel;
        illegal    = ill;
        alu_result = alu;
        #1;
        check_eq({name, "_d_state"}, state, 1);
        check_eq({name, "_d_inst"}, inst, iw_data);
        check_eq({name, "_d_req"}, imem_req, 0);
        step();
        cyc++;
        check_eq({name, "_e_state"}, state, 2);
        check_eq({name, "_e_inst"}, inst, iw_data);
        step();
        cyc++;
        if (ill) begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            #1;
            check_eq({name, "_t_state"}, state, 7);
            check_eq({name, "_t_trap"}, trap, 1);
            check_eq({name, "_t_cause"}, trap_cause, 1);
            check_eq({name, "_t_req"}, imem_req, 0);
            $display("TXN %s pc=%h trap cause=%0d", name, pc, trap_cause);
            return;
        end
        if (ld || st) begin
            for (int w = 0; w <= dw; w++) begin
                dmem_ack = (w == dw);
                imem_ack = 1'b1;
                #1;
                check_eq({name, "_m_state"}, state, 3);
                check_eq({name, "_m_req"}, dmem_req, 1);
                check_eq({name, "_m_we"}, dmem_we, st);
                check_eq({name, "_m_cap"}, ld_capture, (w == dw) && !st);
                check_eq({name, "_m_ireq"}, imem_req, 0);
                step();
                cyc++;
            end
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        check_eq({name, "_w_state"}, state, 4);
        check_eq({name, "_w_retire"}, retire, !exp_trap);
        check_eq({name, "_w_rdwren"}, rd_wren, exp_rdw);
        check_eq({name, "_w_cycles"}, cyc + 1, exp_cycles);
        step();
        cyc++;
        check_eq({name, "_n_state"}, state, exp_trap ? 32'd7 : 32'd0);
        check_eq({name, "_n_pc"}, pc, exp_next);
        check_eq({name, "_n_trap"}, trap, exp_trap);
        if (exp_trap) begin
            check_eq({name, "_n_cause"}, trap_cause, 3);
        end
        $display("TXN %s pc=%h next=%h cycles=%0d", name, exp_pc, pc, cyc);
        idle_inputs();
    endtask

    task automatic trap_hold(input string name, input logic [31:0] exp_pc);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq({name, "_hold_state"}, state, 7);
            check_eq({name, "_hold_ireq"}, imem_req, 0);
            check_eq({name, "_hold_dreq"}, dmem_req, 0);
            check_eq({name, "_hold_pc"}, pc, exp_pc);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        step();
        do_reset();

        //        name     inst          iw dw ld st rdw ps ill alu           pc         next      rdw trap cyc
        run_inst("nop",    32'h0000_0013, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h100, 32'h104, 1,  0,   4);
        run_inst("load",   32'h0000_2083, 3, 2, 1, 0, 1, 0, 0, 32'h0,        32'h104, 32'h108, 1,  0,   10);
        run_inst("store",  32'h0010_2023, 1, 0, 0, 1, 1, 0, 0, 32'h0,        32'h108, 32'h10c, 0,  0,   6);
        run_inst("branch", 32'h0000_006f, 0, 0, 0, 0, 1, 1, 0, 32'h0000_0205, 32'h10c, 32'h204, 1,  0,   4);
        run_inst("misal",  32'h0000_006f, 0, 0, 0, 0, 1, 1, 0, 32'h0000_0206, 32'h204, 32'h204, 0,  1,   4);
        trap_hold("misal", 32'h204);

        do_reset();
        run_inst("illegal", 32'hffff_ffff, 0, 0, 0, 0, 1, 0, 1, 32'h0,       32'h100, 32'h100, 0,  0,   0);
        trap_hold("illegal", 32'h100);
        do_reset();

`ifdef MC_SEQ_TIMEOUT_EN
        run_inst("late_ack", 32'h0000_0013, 4, 0, 0, 0, 0, 0, 0, 32'h0,     32'h100, 32'h104, 0,  0,   8);
        for (int w = 0; w <= 4; w++) begin
            #1;
            check_eq("tmo_f_req", imem_req, 1);
            check_eq("tmo_f_state", state, 0);
            step();
        end
        #1;
        check_eq("tmo_state", state, 7);
        check_eq("tmo_cause", trap_cause, 2);
        check_eq("tmo_req", imem_req, 0);
        check_eq("tmo_pc", pc, 32'h104);
        $display("TXN timeout pc=%h cause=%0d", pc, trap_cause);
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
